johnson_decoder: RTL

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_pkg.sv | 26 ++
 rtl/johnson_code_check.sv | 33 +++
 rtl/johnson_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code decoder: FSM states,
// index-width helper and the error-counter ceiling.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    LOCKED   = 2'd2
  } jd_state_e;

  localparam int N_DEFAULT = 4;

  // A code of width n walks through 2n states, so the index needs clog2(2n) bits.
  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int IDX_W = idx_width(N_DEFAULT);

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode for one Johnson code word.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  code_i,
  output logic          legal_o,
  output logic [IW-1:0] idx_o
);

  int ones;
  int trans;
  int idx_int;

  // A legal word has at most one 0/1 boundary between adjacent bits:
  // that covers 1..10..0, 0..01..1, all-ones and all-zeros.
  always_comb begin
    ones  = $countones(code_i);
    trans = $countones(code_i[N-2:0] ^ code_i[N-1:1]);
    legal_o = (trans <= 1);

    idx_int = 0;
    if (code_i[N-1]) begin
      idx_int = ones;
    end else if (ones != 0) begin
      idx_int = 2 * N - ones;
    end
    idx_o = IW'(idx_int);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code decoder: registered index, legality/sequence error pulses,
// saturating error count and a lock tracker over in-order samples.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 4,
  localparam int IW       = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  // run counts the reference plus following in-order samples; it must reach LOCK_CNT+1.
  localparam int              RUN_W    = $clog2(LOCK_CNT + 2);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);
  localparam logic [IW-1:0]    IDX_LAST = IW'(2 * N - 1);

  logic          dec_legal;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] succ_idx;
  logic          in_order;

  jd_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           idx_valid_q, idx_valid_d;
  logic           illegal_q, illegal_d;
  logic           seq_err_q, seq_err_d;
  logic           locked_q, locked_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  johnson_code_check #(
    .N (N)
  ) u_code_check (
    .code_i  (code_in),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  assign succ_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  assign in_order = (dec_idx == succ_idx);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;

    if (code_valid) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        err_cnt_d = err_cnt_inc(err_cnt_q);
        state_d   = UNLOCKED;
        run_d     = '0;
      end else begin
        idx_d       = dec_idx;
        idx_valid_d = 1'b1;
        case (state_q)
          UNLOCKED: begin
            state_d = TRACKING;
            run_d   = RUN_ONE;
          end
          TRACKING, LOCKED: begin
            if (!in_order) begin
              // Repeats land here too, since a repeat is never the successor.
              seq_err_d = 1'b1;
              err_cnt_d = err_cnt_inc(err_cnt_q);
              state_d   = TRACKING;
              run_d     = RUN_ONE;
            end else if (state_q == TRACKING) begin
              run_d = run_q + RUN_ONE;
              if (run_q >= RUN_LOCK) begin
                state_d = LOCKED;
              end
            end
          end
          default: begin
            state_d = UNLOCKED;
            run_d   = '0;
          end
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      run_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule
